arrow_sequencer: RTL and testbench
==================================

// Module: arrow_sequencer
// PURPOSE
//  Output-side counterpart of the button input path. Reads the dance chart from an external
//  synchronous ROM and emits one arrow mask per step: Up, Down, Left, Right in bits [0..3].
//  Both players are judged against the same target_mask. arrow_lamp drives the playfield LEDs.
//  Started, paused and aborted by the game controller.
// PARAMETERS
//  STEP_CYCLES    12_500_000  clocks per chart step (250 ms at 50 MHz); must be >= 4
//  CHART_DEPTH    64          ROM entries; power of two
//  ADDR_W         6           log2(CHART_DEPTH)
//  WINDOW_CYCLES  5_000_000   live-window length per step; used only with the macro, <= STEP_CYCLES
// PORTS
//  clock        in   1       system clock, 50 MHz
//  reset        in   1       synchronous, active-high; only reset
//  start        in   1       1-cycle pulse: begin chart from entry 0 (controller enable_song edge)
//  pause        in   1       level: freeze step timing and outputs
//  abort        in   1       1-cycle pulse: stop immediately (game over)
//  rom_addr     out  ADDR_W  chart ROM address
//  rom_data     in   5       [3:0] arrow mask, [4] end-of-chart; valid 1 cycle after rom_addr
//  target_mask  out  4       arrows required in the current step
//  target_valid out  1       target_mask is live for judging
//  step_strobe  out  1       1-cycle pulse when a new step is presented
//  arrow_lamp   out  4       registered copy of target_mask, gated by target_valid
//  step_index   out  ADDR_W  index of the presented entry
//  busy         out  1       high from start until done or abort
//  done         out  1       1-cycle pulse: end-of-chart reached
// BEHAVIOUR
//  Reset: state IDLE; every output is 0, rom_addr included.
//  FSM states: IDLE, FETCH, PLAY, DONE.
//  - IDLE --start--> FETCH: rom_addr=0, busy=1.
//  - FETCH: waits 2 cycles (address, then data registered), then goes to PLAY.
//    If entry[4]=1, goes to DONE instead.
//  - Entering PLAY presents the entry:
//    target_mask=entry[3:0], target_valid=|entry[3:0], step_strobe=1, step_index=address.
//    The step timer loads STEP_CYCLES-1. Prefetch of address+1 is issued the same cycle.
//  - PLAY: the timer decrements each unpaused cycle. At 0, the prefetched entry is presented
//    (same rules as entering PLAY) and the address increments.
//    If the prefetched entry has [4]=1, or the presented index is CHART_DEPTH-1 (no wrap),
//    the state goes to DONE instead.
//  - DONE: target_mask, target_valid and lamps clear. done=1 for one cycle, busy=0, then IDLE.
//  Latency: start to first step_strobe = 3 cycles. Step-to-step period = STEP_CYCLES unpaused cycles.
//  pause=1: the timer holds and outputs hold; no step_strobe, no prefetch changes.
//    Pause coincident with timer==0 defers the step until the first unpaused cycle.
//  start while busy restarts from entry 0 (FETCH); the outputs clear the same cycle.
//  abort while busy: IDLE next cycle, outputs 0, no done pulse. abort beats start if simultaneous.
//  abort/start/pause in IDLE or DONE: only start has effect, and only in IDLE.
//  Mask 0 entries are rests: step_strobe still pulses, target_valid=0.
// CONFIGURATION
//  ARROW_SEQ_WINDOW_EN defined: target_valid (and arrow_lamp) are high only for the first
//    WINDOW_CYCLES unpaused cycles of each step, then drop for the remainder.
//    A window counter is added; it freezes on pause.
//  Not defined: target_valid is high for the whole step when the mask is nonzero.
//    No window counter and no WINDOW_CYCLES logic.
// STRUCTURE
//  Shared package ddr_pkg holds:
//    - arrow bit indices: UP=0, DOWN=1, LEFT=2, RIGHT=3
//    - chart entry field positions: MASK=[3:0], END=4
//    - FSM state encoding
//    - default STEP_CYCLES
//  One sub-module: step_timer, a loadable down-counter with hold (pause) and terminal-count
//    flag. It is instantiated for the step timer and, with the macro, again for the window.
// TESTING (bench params: STEP_CYCLES=8, CHART_DEPTH=8, WINDOW_CYCLES=3)
//  1. ROM {1,2,4,8,END}; start -> strobes at +3, +11, +19, +27;
//     masks 1,2,4,8; done at step 4; busy falls.
//  2. ROM {3,0,5,END}; 2nd step is a rest -> step_strobe=1, target_valid=0, target_mask=0.
//  3. pause held 5 cycles mid-step 1 -> next strobe delayed exactly 5 cycles, outputs held.
//     Pause at timer==0 -> strobe on first unpaused cycle.
//  4. ROM with no END in 8 entries -> step_index 7 presented, then done; rom_addr never wraps.
//  5. abort in step 2 -> outputs 0 next cycle, no done.
//     start mid-chart -> restarts at index 0. Reset mid-step -> all outputs 0 next cycle.
//  6. Macro on, ROM {F,END} -> target_valid high 3 cycles after strobe, low 5 cycles.
//     Macro off -> high 8 cycles.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the dance-game datapath: arrow bit positions,
// chart ROM entry layout, sequencer FSM encoding and default timing.
`timescale 1ns/1ps
package ddr_pkg;

  // Arrow bit indices within a 4-bit arrow mask
  localparam int ARROW_UP    = 0;
  localparam int ARROW_DOWN  = 1;
  localparam int ARROW_LEFT  = 2;
  localparam int ARROW_RIGHT = 3;

  // Chart ROM entry layout: [3:0] arrow mask, [4] end-of-chart marker
  localparam int ENTRY_MASK_LSB = 0;
  localparam int ENTRY_MASK_MSB = 3;
  localparam int ENTRY_END      = 4;
  localparam int ENTRY_W        = 5;

  // 250 ms per step at 50 MHz
  localparam int DEFAULT_STEP_CYCLES = 12_500_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Extract the arrow mask field of a chart entry
  function automatic logic [3:0] entry_mask(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_MASK_MSB:ENTRY_MASK_LSB];
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with hold and terminal-count flag. Counts down to
// zero and sticks there until reloaded; load takes priority over hold.
`timescale 1ns/1ps
module step_timer #(
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         hold,
  output logic         tc
);

  logic [W-1:0] count_reg;

  // Reload on request, otherwise decrement on every non-held cycle until zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (!hold && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/arrow_sequencer.sv
// Chart playback: reads arrow masks from an external synchronous ROM and
// presents one step every STEP_CYCLES unpaused clocks. Optional feature
// macro ARROW_SEQ_WINDOW_EN limits target_valid to the first WINDOW_CYCLES
// unpaused cycles of each step.
`timescale 1ns/1ps
module arrow_sequencer
  import ddr_pkg::*;
#(
`ifdef ARROW_SEQ_WINDOW_EN
  parameter int WINDOW_CYCLES = 5_000_000,
`endif
  parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES,
  parameter int CHART_DEPTH = 64,
  parameter int ADDR_W      = $clog2(CHART_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [3:0]        target_mask,
  output logic              target_valid,
  output logic              step_strobe,
  output logic [3:0]        arrow_lamp,
  output logic [ADDR_W-1:0] step_index,
  output logic              busy,
  output logic              done
);

  localparam int                TIMER_W   = $clog2(STEP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_DEPTH - 1);

  seq_state_t        state_reg, state_next;
  logic              fetch_ready_reg;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic [ADDR_W-1:0] step_index_reg, step_index_next;
  logic [3:0]        mask_reg, mask_next;
  logic [3:0]        lamp_reg, lamp_next;
  logic              valid_reg, valid_next;
  logic              strobe_reg, strobe_next;
  logic              kill, restart, present, finish;
  logic              step_tc;

  step_timer #(.W(TIMER_W)) u_step_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (present),
    .load_value (TIMER_W'(STEP_CYCLES - 1)),
    .hold       (pause),
    .tc         (step_tc)
  );

`ifdef ARROW_SEQ_WINDOW_EN
  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  logic window_tc;

  step_timer #(.W(WIN_W)) u_window_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (present),
    .load_value (WIN_W'(WINDOW_CYCLES - 1)),
    .hold       (pause),
    .tc         (window_tc)
  );
`endif

  // Decode this cycle's event: abort beats start, start beats stepping;
  // a step is presented or the chart finishes only on an unpaused cycle
  always_comb begin
    kill    = abort && ((state_reg == ST_FETCH) || (state_reg == ST_PLAY));
    restart = !kill && start && (state_reg != ST_DONE);
    present = 1'b0;
    finish  = 1'b0;
    if (!kill && !restart && !pause) begin
      if ((state_reg == ST_FETCH) && fetch_ready_reg) begin
        if (rom_data[ENTRY_END]) finish = 1'b1;
        else                     present = 1'b1;
      end else if ((state_reg == ST_PLAY) && step_tc) begin
        if (rom_data[ENTRY_END] || (step_index_reg == LAST_ADDR)) finish = 1'b1;
        else                                                      present = 1'b1;
      end
    end
  end

  // State register plus the FETCH phase flag (address cycle, then data cycle)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      fetch_ready_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_ready_reg <= (state_reg == ST_FETCH) && !restart && !kill;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    if (kill)                        state_next = ST_IDLE;
    else if (restart)                state_next = ST_FETCH;
    else if (finish)                 state_next = ST_DONE;
    else if (present)                state_next = ST_PLAY;
    else if (state_reg == ST_DONE)   state_next = ST_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    busy = (state_reg == ST_FETCH) || (state_reg == ST_PLAY);
    done = (state_reg == ST_DONE);
  end

  // Next values of the presented step; prefetch stops at the last ROM entry
  always_comb begin
    rom_addr_next   = rom_addr_reg;
    step_index_next = step_index_reg;
    mask_next       = mask_reg;
    valid_next      = valid_reg;
    strobe_next     = 1'b0;
    if (kill || restart) begin
      rom_addr_next   = '0;
      step_index_next = '0;
      mask_next       = 4'd0;
      valid_next      = 1'b0;
    end else if (present) begin
      mask_next       = entry_mask(rom_data);
      valid_next      = |entry_mask(rom_data);
      strobe_next     = 1'b1;
      step_index_next = rom_addr_reg;
      rom_addr_next   = (rom_addr_reg == LAST_ADDR) ? rom_addr_reg : rom_addr_reg + 1'b1;
    end else if (finish || (state_reg == ST_DONE)) begin
      mask_next  = 4'd0;
      valid_next = 1'b0;
    end
`ifdef ARROW_SEQ_WINDOW_EN
    else if ((state_reg == ST_PLAY) && !pause && window_tc) begin
      valid_next = 1'b0;
    end
`endif
  end

  // Each lamp follows its arrow bit while the step is live
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lamp
      assign lamp_next[gi] = mask_next[gi] & valid_next;
    end
  endgenerate

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr_reg   <= '0;
      step_index_reg <= '0;
      mask_reg       <= 4'd0;
      valid_reg      <= 1'b0;
      strobe_reg     <= 1'b0;
      lamp_reg       <= 4'd0;
    end else begin
      rom_addr_reg   <= rom_addr_next;
      step_index_reg <= step_index_next;
      mask_reg       <= mask_next;
      valid_reg      <= valid_next;
      strobe_reg     <= strobe_next;
      lamp_reg       <= lamp_next;
    end
  end

  assign rom_addr     = rom_addr_reg;
  assign step_index   = step_index_reg;
  assign target_mask  = mask_reg;
  assign target_valid = valid_reg;
  assign step_strobe  = strobe_reg;
  assign arrow_lamp   = lamp_reg;

endmodule

// File: tb/tb_arrow_sequencer.sv
// Bench for arrow_sequencer. Expected waveforms come from a schedule model:
// each step lasts until STEP unpaused cycles have elapsed, the chart starts
// 3 cycles after start and ends at END or after the last ROM entry.
`timescale 1ns/1ps
module tb_arrow_sequencer;

  localparam int STEP  = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int WIN   = 3;
  localparam int MAXC  = 160;
`ifdef ARROW_SEQ_WINDOW_EN
  localparam bit WIN_ON = 1'b1;
`else
  localparam bit WIN_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, start, pause, abort;
  logic [AW-1:0] rom_addr;
  logic [4:0]    rom_data;
  logic [3:0]    target_mask, arrow_lamp;
  logic          target_valid, step_strobe, busy, done;
  logic [AW-1:0] step_index;

  arrow_sequencer #(
`ifdef ARROW_SEQ_WINDOW_EN
    .WINDOW_CYCLES (WIN),
`endif
    .STEP_CYCLES   (STEP),
    .CHART_DEPTH   (DEPTH),
    .ADDR_W        (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .target_mask  (target_mask),
    .target_valid (target_valid),
    .step_strobe  (step_strobe),
    .arrow_lamp   (arrow_lamp),
    .step_index   (step_index),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Synchronous chart ROM
  logic [4:0] rom [DEPTH];
  always @(posedge clock) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input int cyc,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Expected per-cycle values, indexed by cycle within a run (cycle 0 = start)
  bit         pause_pat [MAXC];
  logic [3:0] e_mask    [MAXC];
  bit         e_valid   [MAXC];
  bit         e_strobe  [MAXC];
  bit         e_busy    [MAXC];
  bit         e_done    [MAXC];
  bit         chk_idx   [MAXC];
  bit         chk_addr  [MAXC];
  int         e_idx     [MAXC];
  int         e_addr    [MAXC];
  int         run_len;
  int         e_strobes;
  int         e_done_at;

  task automatic clear_pause();
    for (int c = 0; c < MAXC; c++) pause_pat[c] = 1'b0;
  endtask

  task automatic build_model(input int kill_at);
    int x, y, idx, nup;
    logic [3:0] m;
    for (int c = 0; c < MAXC; c++) begin
      e_mask[c] = 4'd0; e_valid[c] = 1'b0; e_strobe[c] = 1'b0; e_busy[c] = 1'b0;
      e_done[c] = 1'b0; chk_idx[c] = 1'b0; chk_addr[c] = 1'b0; e_idx[c] = 0; e_addr[c] = 0;
    end
    e_strobes = 0;
    e_done_at = -1;
    for (int c = 1; c <= 2; c++) begin
      e_busy[c] = 1'b1; chk_addr[c] = 1'b1; e_addr[c] = 0;
    end
    if (rom[0][4]) begin
      e_done_at = 3;
    end else begin
      x = 3; idx = 0;
      while (x < MAXC && e_done_at < 0) begin
        m = rom[idx][3:0];
        nup = 0; y = x;
        e_strobes++;
        while (nup < STEP && y < MAXC) begin
          e_busy[y]   = 1'b1;
          e_mask[y]   = m;
          e_valid[y]  = (m != 4'd0) && (!WIN_ON || nup < WIN);
          e_strobe[y] = (y == x);
          chk_idx[y]  = (y == x);
          e_idx[y]    = idx;
          chk_addr[y] = 1'b1;
          e_addr[y]   = (idx == DEPTH - 1) ? idx : idx + 1;
          if (!pause_pat[y]) nup++;
          y++;
        end
        if (y >= MAXC) break;
        if (idx == DEPTH - 1) e_done_at = y;
        else if (rom[idx + 1][4]) e_done_at = y;
        else begin
          idx++;
          x = y;
        end
      end
    end
    if (e_done_at >= 0 && e_done_at < MAXC) e_done[e_done_at] = 1'b1;
    run_len = (e_done_at >= 0) ? e_done_at + 3 : MAXC;
    if (run_len > MAXC) run_len = MAXC;
    if (kill_at > 0 && (e_done_at < 0 || kill_at < e_done_at)) begin
      for (int c = kill_at + 1; c < MAXC; c++) begin
        e_mask[c] = 4'd0; e_valid[c] = 1'b0; e_strobe[c] = 1'b0; e_busy[c] = 1'b0;
        e_done[c] = 1'b0; chk_idx[c] = 1'b1; e_idx[c] = 0; chk_addr[c] = 1'b1; e_addr[c] = 0;
      end
      run_len = kill_at + 3;
      e_done_at = -1;
    end
  endtask

  // kill_kind: 0 none, 1 abort, 2 reset; max_len > 0 truncates the run
  task automatic do_run(input string name, input int kill_at, input int kill_kind, input int max_len);
    int seen;
    build_model(kill_at);
    if (max_len > 0 && max_len < run_len) run_len = max_len;
    seen = 0;
    for (int c = 0; c < run_len; c++) begin
      @(posedge clock); #1;
      start = (c == 0);
      pause = pause_pat[c];
      abort = (kill_kind == 1) && (c == kill_at);
      reset = (kill_kind == 2) && (c == kill_at);
      @(negedge clock);
      if (c >= 1) begin
        check_value({name, ".busy"},   c, 32'(busy),         32'(e_busy[c]));
        check_value({name, ".done"},   c, 32'(done),         32'(e_done[c]));
        check_value({name, ".strobe"}, c, 32'(step_strobe),  32'(e_strobe[c]));
        check_value({name, ".mask"},   c, 32'(target_mask),  32'(e_mask[c]));
        check_value({name, ".valid"},  c, 32'(target_valid), 32'(e_valid[c]));
        check_value({name, ".lamp"},   c, 32'(arrow_lamp),   32'(e_mask[c] & {4{e_valid[c]}}));
        if (chk_idx[c])  check_value({name, ".index"}, c, 32'(step_index), 32'(e_idx[c]));
        if (chk_addr[c]) check_value({name, ".addr"},  c, 32'(rom_addr),   32'(e_addr[c]));
        if (step_strobe) seen++;
      end
    end
    @(posedge clock); #1;
    start = 1'b0; pause = 1'b0; abort = 1'b0; reset = 1'b0;
    $display("run %s: cycles=%0d strobes seen=%0d expected=%0d done_at=%0d",
             name, run_len, seen, e_strobes, e_done_at);
  endtask

  task automatic rand_rom();
    int end_pos;
    for (int i = 0; i < DEPTH; i++) rom[i] = {1'b0, 4'($urandom_range(0, 15))};
    end_pos = $urandom_range(0, DEPTH);
    if (end_pos < DEPTH) rom[end_pos] = 5'h10;
  endtask

  initial begin
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    clear_pause();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_value("reset.busy",   0, 32'(busy),         32'd0);
    check_value("reset.done",   0, 32'(done),         32'd0);
    check_value("reset.strobe", 0, 32'(step_strobe),  32'd0);
    check_value("reset.mask",   0, 32'(target_mask),  32'd0);
    check_value("reset.valid",  0, 32'(target_valid), 32'd0);
    check_value("reset.lamp",   0, 32'(arrow_lamp),   32'd0);
    check_value("reset.index",  0, 32'(step_index),   32'd0);
    check_value("reset.addr",   0, 32'(rom_addr),     32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic four-step chart
    do_run("chart1", 0, 0, 0);

    // Rest step in the middle
    rom = '{5'h03, 5'h00, 5'h05, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
    do_run("rest", 0, 0, 0);

    // Pause mid-step and pause landing on the step boundary
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    for (int c = 5; c < 10; c++) pause_pat[c] = 1'b1;
    pause_pat[23] = 1'b1;
    pause_pat[24] = 1'b1;
    do_run("pause", 0, 0, 0);
    clear_pause();

    // No END marker: last ROM entry then done
    rom = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h0E, 5'h0C, 5'h08, 5'h09};
    do_run("noend", 0, 0, 0);

    // Abort in step 2, restart mid-chart, reset mid-step
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    do_run("abort", 14, 1, 0);
    rom = '{5'h05, 5'h06, 5'h07, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D};
    do_run("pre_restart", 0, 0, 20);
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    do_run("restart", 0, 0, 0);
    do_run("reset_mid", 15, 2, 0);

    // Randomized charts, pauses and aborts
    for (int r = 0; r < 14; r++) begin
      rand_rom();
      clear_pause();
      for (int c = 3; c < MAXC; c++) pause_pat[c] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) do_run($sformatf("rand%0d_abort", r), $urandom_range(3, 40), 1, 0);
      else                           do_run($sformatf("rand%0d", r), 0, 0, 0);
    end

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
